// File: rtl/nor_gate_checker_pkg.sv
// Shared definitions for the NOR gate-unit self-test checker:
// FSM state encoding, vector bookkeeping and a small bit-count helper.
package nor_gate_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NUM_VEC = 4;

    // Vectors are walked in ascending order {A,B} = 00, 01, 10, 11.
    localparam logic [1:0] VEC_FIRST = 2'd0;
    localparam logic [1:0] VEC_LAST  = 2'd3;

    // Number of set bits among the three compared gate outputs (0..3).
    function automatic logic [1:0] popcount3(input logic [2:0] x);
        return {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
    endfunction

endpackage

// File: rtl/nor_gate_checker_if.sv
// Bundle between the checker and the gate unit under test / run controller.
// master = checker side, slave = gate unit plus whoever issues start.
interface nor_gate_checker_if
    import nor_gate_checker_pkg::*;
#(
    parameter int ERR_W = 4
) ();

    logic               start;
    logic               drvA;
    logic               drvB;
    logic               obsAND;
    logic               obsOR;
    logic               obsNOT;
    logic               busy;
    logic               done;
    logic               pass;
    logic [ERR_W-1:0]   errCount;
    logic [NUM_VEC-1:0] failVec;

    modport master (
        input  start, obsAND, obsOR, obsNOT,
        output drvA, drvB, busy, done, pass, errCount, failVec
    );

    modport slave (
        output start, obsAND, obsOR, obsNOT,
        input  drvA, drvB, busy, done, pass, errCount, failVec
    );

endinterface

// File: rtl/nor_gate_checker_gate_expect.sv
// Golden truth table for the gate unit: what AND/OR/NOT should read for A,B.
module gate_expect (
    input  logic A,
    input  logic B,
    output logic expAND,
    output logic expOR,
    output logic expNOT
);

    // Reference behaviour, independent of how the unit under test is built.
    always_comb begin
        expAND = A & B;
        expOR  = A | B;
        expNOT = ~A;
    end

endmodule

// File: rtl/nor_gate_checker.sv
// Self-test sequencer for the NOR-built gate unit: walks all four input
// vectors, lets each settle, compares the three outputs against the golden
// table and accumulates a saturating mismatch count, per-vector fail bits
// and an overall pass flag.
module nor_gate_checker
    import nor_gate_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic                clk,
    input  logic                reset,
    nor_gate_checker_if.master  bus
);

    localparam int WC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W+1:0] ERR_MAX = {2'b00, {ERR_W{1'b1}}};

    state_e               state_q, state_d;
    logic [1:0]           vec_q, vec_d;
    logic [WC_W-1:0]      waitcnt_q, waitcnt_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [NUM_VEC-1:0]   fail_q, fail_d;
    logic                 pass_q, pass_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 exp_and_s, exp_or_s, exp_not_s;
    logic [2:0]           mismatch_s;
    logic [1:0]           mcount_s;
    logic [ERR_W+1:0]     err_sum_s;
    logic [NUM_VEC-1:0]   fail_upd_s;

    // The drive register is the vector index itself, so golden values track
    // exactly what the unit is being fed.
    gate_expect u_expect (
        .A      (vec_q[1]),
        .B      (vec_q[0]),
        .expAND (exp_and_s),
        .expOR  (exp_or_s),
        .expNOT (exp_not_s)
    );

    // Sequencing, comparison and result accumulation for one test run.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        waitcnt_d = waitcnt_q;
        err_d     = err_q;
        fail_d    = fail_q;
        pass_d    = pass_q;

        mismatch_s = {bus.obsAND ^ exp_and_s, bus.obsOR ^ exp_or_s, bus.obsNOT ^ exp_not_s};
        mcount_s   = popcount3(mismatch_s);
        err_sum_s  = {2'b00, err_q} + {{ERR_W{1'b0}}, mcount_s};
        fail_upd_s = fail_q | ((mcount_s != 2'd0) ? (4'b0001 << vec_q) : 4'b0000);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = WAIT;
                    vec_d     = VEC_FIRST;
                    waitcnt_d = '0;
                    err_d     = '0;
                    fail_d    = '0;
                    pass_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                waitcnt_d = waitcnt_q + WC_W'(1);
                if (waitcnt_q == WC_LAST) begin
                    state_d = CHECK;
                end else begin
                    state_d = WAIT;
                end
            end
            CHECK: begin
                err_d  = (err_sum_s > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum_s[ERR_W-1:0];
                fail_d = fail_upd_s;
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                    pass_d  = (fail_upd_s == 4'b0000);
                end else begin
                    state_d   = WAIT;
                    vec_d     = vec_q + 2'd1;
                    waitcnt_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they register in
        // step with the state itself.
        busy_d = (state_d == WAIT) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    // State and result registers; synchronous reset aborts any run in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            vec_q     <= 2'd0;
            waitcnt_q <= '0;
            err_q     <= '0;
            fail_q    <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            waitcnt_q <= waitcnt_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.drvA     = vec_q[1];
    assign bus.drvB     = vec_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.errCount = err_q;
    assign bus.failVec  = fail_q;

endmodule

// File: tb/tb_nor_gate_checker.sv
// Scoreboard bench: stimulus pushes expected run results, per-DUT monitors
// pop and compare whenever done is presented.
module tb_nor_gate_checker;
    import nor_gate_checker_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         start_cyc;
        int         lat;
        logic       pass;
        int         err;
        logic [3:0] fv;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    logic rst_a, rst_bc;
    int   mode_a;

    nor_gate_checker_if #(.ERR_W(4)) if_a ();
    nor_gate_checker_if #(.ERR_W(2)) if_b ();
    nor_gate_checker_if #(.ERR_W(4)) if_c ();

    // Gate unit model: 0 = NOR-built correct, 1 = OR stuck 0,
    // 2 = NOT wired to A, 3 = all outputs inverted. Returns {AND,OR,NOT}.
    function automatic logic [2:0] gate_unit(input logic a, input logic b, input int mode);
        logic na, nb, nab, g_and, g_or, g_not;
        na    = ~(a | a);
        nb    = ~(b | b);
        nab   = ~(a | b);
        g_and = ~(na | nb);
        g_or  = ~(nab | nab);
        g_not = na;
        case (mode)
            1:       return {g_and, 1'b0, g_not};
            2:       return {g_and, g_or, a};
            3:       return {~g_and, ~g_or, ~g_not};
            default: return {g_and, g_or, g_not};
        endcase
    endfunction

    logic [2:0] obs_a, obs_b, obs_c;
    assign obs_a = gate_unit(if_a.drvA, if_a.drvB, mode_a);
    assign obs_b = gate_unit(if_b.drvA, if_b.drvB, 3);
    assign obs_c = gate_unit(if_c.drvA, if_c.drvB, 0);
    assign if_a.obsAND = obs_a[2];
    assign if_a.obsOR  = obs_a[1];
    assign if_a.obsNOT = obs_a[0];
    assign if_b.obsAND = obs_b[2];
    assign if_b.obsOR  = obs_b[1];
    assign if_b.obsNOT = obs_b[0];
    assign if_c.obsAND = obs_c[2];
    assign if_c.obsOR  = obs_c[1];
    assign if_c.obsNOT = obs_c[0];

    nor_gate_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut_a (.clk(clk), .reset(rst_a),  .bus(if_a));
    nor_gate_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) dut_b (.clk(clk), .reset(rst_bc), .bus(if_b));
    nor_gate_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) dut_c (.clk(clk), .reset(rst_bc), .bus(if_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic pass,
                              input int err, input logic [3:0] fv);
        chk({tag, "_latency"}, cyc - e.start_cyc, e.lat);
        chk({tag, "_pass"}, pass, e.pass);
        chk({tag, "_errCount"}, err, e.err);
        chk({tag, "_failVec"}, fv, e.fv);
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (if_a.done === 1'b1) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                e_a = q_a.pop_front();
                check_done("a", e_a, if_a.pass, int'(if_a.errCount), if_a.failVec);
            end
        end
        if (if_b.done === 1'b1) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
            else begin
                e_b = q_b.pop_front();
                check_done("b", e_b, if_b.pass, int'(if_b.errCount), if_b.failVec);
            end
        end
        if (if_c.done === 1'b1) begin
            if (q_c.size() == 0) chk("c_unexpected_done", 1, 0);
            else begin
                e_c = q_c.pop_front();
                check_done("c", e_c, if_c.pass, int'(if_c.errCount), if_c.failVec);
            end
        end
    end

    task automatic start_a(input int lat, input logic pass, input int err, input logic [3:0] fv);
        if_a.start = 1'b1;
        @(posedge clk);
        #1;
        q_a.push_back('{cyc, lat, pass, err, fv});
        if_a.start = 1'b0;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 60 && q_a.size() != 0; i++) @(posedge clk);
        #1;
        chk("a_drain", q_a.size(), 0);
    endtask

    initial begin
        rst_a       = 1'b1;
        rst_bc      = 1'b1;
        mode_a      = 0;
        if_a.start  = 1'b0;
        if_b.start  = 1'b0;
        if_c.start  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        // Reset state
        chk("rst_busy", if_a.busy, 0);
        chk("rst_done", if_a.done, 0);
        chk("rst_pass", if_a.pass, 0);
        chk("rst_errCount", if_a.errCount, 0);
        chk("rst_failVec", if_a.failVec, 0);
        chk("rst_drv", {if_a.drvA, if_a.drvB}, 0);

        fork
            begin : seq_a
                start_a(12, 1'b1, 0, 4'b0000);
                drain_a();
                mode_a = 1;
                start_a(12, 1'b0, 3, 4'b1110);
                drain_a();
                mode_a = 2;
                start_a(12, 1'b0, 4, 4'b1111);
                drain_a();
                // Abort a run in the first WAIT cycle of vector 2.
                mode_a = 1;
                if_a.start = 1'b1;
                @(posedge clk);
                #1;
                if_a.start = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                chk("pre_rst_drv", {if_a.drvA, if_a.drvB}, 2);
                chk("pre_rst_busy", if_a.busy, 1);
                chk("pre_rst_errCount", if_a.errCount, 1);
                rst_a = 1'b1;
                @(posedge clk);
                #1;
                rst_a = 1'b0;
                chk("abort_busy", if_a.busy, 0);
                chk("abort_done", if_a.done, 0);
                chk("abort_drv", {if_a.drvA, if_a.drvB}, 0);
                chk("abort_errCount", if_a.errCount, 0);
                chk("abort_failVec", if_a.failVec, 0);
                repeat (15) @(posedge clk);
                #1;
                chk("abort_idle_busy", if_a.busy, 0);
                mode_a = 0;
                start_a(12, 1'b1, 0, 4'b0000);
                drain_a();
            end
            begin : seq_b
                if_b.start = 1'b1;
                @(posedge clk);
                #1;
                q_b.push_back('{cyc, 12, 1'b0, 3, 4'b1111});
                if_b.start = 1'b0;
                for (int i = 0; i < 60 && q_b.size() != 0; i++) @(posedge clk);
                #1;
                chk("b_drain", q_b.size(), 0);
            end
            begin : seq_c
                int n0;
                if_c.start = 1'b1;
                @(posedge clk);
                #1;
                n0 = cyc;
                q_c.push_back('{n0,      8, 1'b1, 0, 4'b0000});
                q_c.push_back('{n0 + 10, 8, 1'b1, 0, 4'b0000});
                q_c.push_back('{n0 + 20, 8, 1'b1, 0, 4'b0000});
                for (int k = 0; k < 8; k++) begin
                    chk("c_drv_seq", {if_c.drvA, if_c.drvB}, k / 2);
                    @(posedge clk);
                    #1;
                end
                chk("c_done_cyc8", if_c.done, 1);
                @(posedge clk);
                #1;
                chk("c_idle_busy", if_c.busy, 0);
                chk("c_idle_done", if_c.done, 0);
                chk("c_idle_drv", {if_c.drvA, if_c.drvB}, 3);
                @(posedge clk);
                #1;
                chk("c_rerun_busy", if_c.busy, 1);
                chk("c_rerun_drv", {if_c.drvA, if_c.drvB}, 0);
                repeat (19) @(posedge clk);
                #1;
                if_c.start = 1'b0;
                for (int i = 0; i < 60 && q_c.size() != 0; i++) @(posedge clk);
                repeat (12) @(posedge clk);
                #1;
                chk("c_drain", q_c.size(), 0);
                chk("c_stopped_busy", if_c.busy, 0);
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
